branch_redirect_ctrl: RTL and testbench

Sequences control-flow redirection for the dual-issue pipeline. It sits after the per-way branch-condition logic in EX. It takes each way's resolved branch outcome, selects the oldest taken branch, and drives a valid/ready redirect to fetch. It also squashes younger work and holds a fixed drain window before new resolutions are accepted. The front end is static not-taken, so every taken branch is a redirect.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/sat_counter.sv | 19 +
 rtl/branch_redirect_ctrl.sv | 97 +++++++++
 tb/tb_branch_redirect_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: redirect controller state encoding, issue-way indices
// and the conditional-branch funct3 codes used by the branch-condition logic.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } redirect_state_t;

    localparam int WAY0 = 0;
    localparam int WAY1 = 1;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Picks the oldest taken branch of the dual-issue EX bundle, issues a
// valid/ready redirect to fetch, then holds a fixed drain window.
module branch_redirect_ctrl
    import cpu_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       ex_valid,
    input  logic [1:0]       is_branch,
    input  logic [1:0]       br_taken,
    input  logic [XLEN-1:0]  target0,
    input  logic [XLEN-1:0]  target1,
    input  logic             redirect_ready,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             kill_way1,
    output logic             flush_younger,
    output logic             busy,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    redirect_state_t state_q, state_d;
    logic [3:0]      drain_q, drain_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            t0, t1, handshake;

    assign t0 = ex_valid[WAY0] & is_branch[WAY0] & br_taken[WAY0];
    assign t1 = ex_valid[WAY1] & is_branch[WAY1] & br_taken[WAY1] & ~t0;

    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        target_d  = target_q;
        kill_way1 = 1'b0;
        case (state_q)
            IDLE: begin
                if (t0) begin
                    target_d  = target0;
                    state_d   = REDIRECT;
                    kill_way1 = ex_valid[WAY1];
                end else if (t1) begin
                    target_d = target1;
                    state_d  = REDIRECT;
                end
            end
            REDIRECT: begin
                if (redirect_ready) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                if (drain_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            drain_q  <= 4'd0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            target_q <= target_d;
        end
    end

    // All outputs except kill_way1 decode straight from flops.
    assign redirect_valid = (state_q == REDIRECT);
    assign busy           = (state_q != IDLE);
    assign flush_younger  = busy;
    assign redirect_pc    = target_q & ~XLEN'(1);
    assign handshake      = redirect_valid & redirect_ready;

    sat_counter #(
        .W(CNT_W)
    ) u_taken_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (handshake),
        .count(taken_cnt)
    );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed table-driven bench for branch_redirect_ctrl plus reset and
// counter-saturation sequences.
module tb_branch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  ex_valid = '0, is_branch = '0, br_taken = '0;
    logic [31:0] target0 = '0, target1 = '0;
    logic        redirect_ready = 1'b0;

    logic        rv_a, kill_a, flush_a, busy_a;
    logic [31:0] pc_a;
    logic [15:0] cnt_a;
    logic        rv_b, kill_b, flush_b, busy_b;
    logic [31:0] pc_b;
    logic [1:0]  cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.XLEN(32), .DRAIN_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .is_branch(is_branch),
        .br_taken(br_taken), .target0(target0), .target1(target1),
        .redirect_ready(redirect_ready), .redirect_valid(rv_a),
        .redirect_pc(pc_a), .kill_way1(kill_a), .flush_younger(flush_a),
        .busy(busy_a), .taken_cnt(cnt_a)
    );

    branch_redirect_ctrl #(.XLEN(32), .DRAIN_CYCLES(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .is_branch(is_branch),
        .br_taken(br_taken), .target0(target0), .target1(target1),
        .redirect_ready(redirect_ready), .redirect_valid(rv_b),
        .redirect_pc(pc_b), .kill_way1(kill_b), .flush_younger(flush_b),
        .busy(busy_b), .taken_cnt(cnt_b)
    );

    typedef struct {
        logic [1:0]  ev, ib, bt;
        logic [31:0] t0, t1;
        logic        rdy;
        logic        kill, rv;
        logic [31:0] pc;
        logic        busy;
        logic [15:0] cnt;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl[NV];

    function automatic vec_t mk(input logic [1:0] ev, input logic [1:0] ib,
                                input logic [1:0] bt, input logic [31:0] t0,
                                input logic [31:0] t1, input logic rdy,
                                input logic kill, input logic rv,
                                input logic [31:0] pc, input logic busy,
                                input logic [15:0] cnt);
        vec_t v;
        v.ev = ev; v.ib = ib; v.bt = bt; v.t0 = t0; v.t1 = t1; v.rdy = rdy;
        v.kill = kill; v.rv = rv; v.pc = pc; v.busy = busy; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] ev, input logic [1:0] ib,
                         input logic [1:0] bt, input logic [31:0] t0,
                         input logic [31:0] t1, input logic rdy);
        ex_valid = ev; is_branch = ib; br_taken = bt;
        target0 = t0; target1 = t1; redirect_ready = rdy;
    endtask

    initial begin
        //         ev     ib     bt     t0          t1          rdy   kill rv pc          busy cnt
        // way-0 taken with way 1 valid, then taken pulses during DRAIN
        tbl[0]  = mk(2'b11, 2'b01, 2'b01, 32'h1004,   32'h0,      1'b1, 1, 0, 32'h0,    0, 16'd0);
        tbl[1]  = mk(2'b00, 2'b00, 2'b00, 32'h0,      32'h0,      1'b1, 0, 1, 32'h1004, 1, 16'd0);
        tbl[2]  = mk(2'b11, 2'b11, 2'b11, 32'hdead,   32'hbeef,   1'b1, 0, 0, 32'h1004, 1, 16'd1);
        tbl[3]  = mk(2'b11, 2'b11, 2'b11, 32'hdead,   32'hbeef,   1'b1, 0, 0, 32'h1004, 1, 16'd1);
        tbl[4]  = mk(2'b00, 2'b00, 2'b00, 32'h0,      32'h0,      1'b1, 0, 0, 32'h1004, 0, 16'd1);
        // way-1-only taken with odd target, ready held low for 3 cycles
        tbl[5]  = mk(2'b11, 2'b10, 2'b10, 32'h0,      32'h2001,   1'b0, 0, 0, 32'h1004, 0, 16'd1);
        tbl[6]  = mk(2'b01, 2'b01, 2'b01, 32'hdead,   32'h0,      1'b0, 0, 1, 32'h2000, 1, 16'd1);
        tbl[7]  = mk(2'b00, 2'b00, 2'b00, 32'h0,      32'h0,      1'b0, 0, 1, 32'h2000, 1, 16'd1);
        tbl[8]  = mk(2'b00, 2'b00, 2'b00, 32'h0,      32'h0,      1'b0, 0, 1, 32'h2000, 1, 16'd1);
        tbl[9]  = mk(2'b00, 2'b00, 2'b00, 32'h0,      32'h0,      1'b1, 0, 1, 32'h2000, 1, 16'd1);
        tbl[10] = mk(2'b00, 2'b00, 2'b00, 32'h0,      32'h0,      1'b1, 0, 0, 32'h2000, 1, 16'd2);
        tbl[11] = mk(2'b00, 2'b00, 2'b00, 32'h0,      32'h0,      1'b1, 0, 0, 32'h2000, 1, 16'd2);
        // br_taken without is_branch, is_branch without ex_valid: ignored
        tbl[12] = mk(2'b11, 2'b00, 2'b11, 32'hdead,   32'hbeef,   1'b1, 0, 0, 32'h2000, 0, 16'd2);
        tbl[13] = mk(2'b00, 2'b11, 2'b11, 32'hdead,   32'hbeef,   1'b1, 0, 0, 32'h2000, 0, 16'd2);
        tbl[14] = mk(2'b00, 2'b00, 2'b00, 32'h0,      32'h0,      1'b1, 0, 0, 32'h2000, 0, 16'd2);
        // both ways taken: way 0 wins, single handshake
        tbl[15] = mk(2'b11, 2'b11, 2'b11, 32'h100,    32'h200,    1'b1, 1, 0, 32'h2000, 0, 16'd2);
        tbl[16] = mk(2'b00, 2'b00, 2'b00, 32'h0,      32'h0,      1'b1, 0, 1, 32'h100,  1, 16'd2);
        tbl[17] = mk(2'b00, 2'b00, 2'b00, 32'h0,      32'h0,      1'b1, 0, 0, 32'h100,  1, 16'd3);
        tbl[18] = mk(2'b00, 2'b00, 2'b00, 32'h0,      32'h0,      1'b1, 0, 0, 32'h100,  1, 16'd3);
        // way-0 taken with way 1 not valid: no kill; leave it stuck in REDIRECT
        tbl[19] = mk(2'b01, 2'b01, 2'b01, 32'h300,    32'h0,      1'b0, 0, 0, 32'h100,  0, 16'd3);
        tbl[20] = mk(2'b00, 2'b00, 2'b00, 32'h0,      32'h0,      1'b0, 0, 1, 32'h300,  1, 16'd3);
        tbl[21] = mk(2'b00, 2'b00, 2'b00, 32'h0,      32'h0,      1'b0, 0, 1, 32'h300,  1, 16'd3);

        // Reset state
        @(negedge clk);
        #1;
        check("rst redirect_valid", 0, 32'(rv_a), 32'd0);
        check("rst redirect_pc", 0, pc_a, 32'h0);
        check("rst busy", 0, 32'(busy_a), 32'd0);
        check("rst flush_younger", 0, 32'(flush_a), 32'd0);
        check("rst taken_cnt", 0, 32'(cnt_a), 32'd0);
        check("rst kill_way1", 0, 32'(kill_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tbl[i].ev, tbl[i].ib, tbl[i].bt, tbl[i].t0, tbl[i].t1, tbl[i].rdy);
            #1;
            check("kill_way1", i, 32'(kill_a), 32'(tbl[i].kill));
            check("redirect_valid", i, 32'(rv_a), 32'(tbl[i].rv));
            check("redirect_pc", i, pc_a, tbl[i].pc);
            check("busy", i, 32'(busy_a), 32'(tbl[i].busy));
            check("flush_younger", i, 32'(flush_a), 32'(tbl[i].busy));
            check("taken_cnt", i, 32'(cnt_a), 32'(tbl[i].cnt));
        end
        check("sat cnt after 3", 0, 32'(cnt_b), 32'd3);

        // Asynchronous reset while in REDIRECT
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async rst redirect_valid", 0, 32'(rv_a), 32'd0);
        check("async rst busy", 0, 32'(busy_a), 32'd0);
        check("async rst flush_younger", 0, 32'(flush_a), 32'd0);
        check("async rst taken_cnt", 0, 32'(cnt_a), 32'd0);
        check("async rst redirect_pc", 0, pc_a, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post rst busy", 0, 32'(busy_a), 32'd0);
        check("post rst redirect_valid", 0, 32'(rv_a), 32'd0);
        check("post rst taken_cnt", 0, 32'(cnt_a), 32'd0);

        // Back-to-back redirects: five accepted within 20 cycles
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            drive(2'b01, 2'b01, 2'b01, 32'h400, 32'h0, 1'b1);
        end
        @(negedge clk);
        drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b1);
        #1;
        check("b2b taken_cnt", 0, 32'(cnt_a), 32'd5);
        check("sat taken_cnt", 0, 32'(cnt_b), 32'd3);
        check("b2b busy", 0, 32'(busy_a), 32'd0);
        check("b2b redirect_pc", 0, pc_a, 32'h400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
